// File: rtl/fft_pingpong_ctrl.sv
// Two-bank ping-pong frame buffer sequencer for one memForFFT port; natural-order in, bit-reversed (or natural) out.
// Latency: first out_valid 2 clk after a bank fills; sustains 1 sample/clk in and out when streaming.
// Backpressure: out_ready throttles read issue through 2-entry output FIFO credits; an unreleased bank drops in_ready.
module fft_pingpong_ctrl #(
   parameter int DATA_FFT_SIZE    = 16,
   parameter int SIZE_BITS_ADDRES = 3,
   parameter bit BIT_REVERSE      = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DATA_FFT_SIZE-1:0]    in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [DATA_FFT_SIZE-1:0]    out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic [SIZE_BITS_ADDRES-1:0] out_index,
   output logic                        mem_writeEn,
   output logic [SIZE_BITS_ADDRES:0]   mem_addr,
   output logic [SIZE_BITS_ADDRES:0]   mem_addr_r,
   output logic [DATA_FFT_SIZE-1:0]    mem_inData,
   input  logic [DATA_FFT_SIZE-1:0]    mem_outData,
   output logic                        frame_done
);

   localparam int              AW       = SIZE_BITS_ADDRES;
   localparam logic [AW-1:0]   CNT_LAST = '1;

   typedef enum logic {W_FILL, W_STALL} wstate_t;
   typedef enum logic {R_IDLE, R_RUN}   rstate_t;

   wstate_t r_wstate, w_wstate_nxt;
   rstate_t r_rstate, w_rstate_nxt;

   // Bank bookkeeping: r_wb is the bank being filled, r_ib the bank being read out.
   logic [1:0]    r_full;
   logic          r_wb;
   logic          r_ib;
   logic [AW-1:0] r_wcnt;
   logic [AW-1:0] r_rcnt;

   // One memory read in flight; its data appears on mem_outData the next clk.
   logic          r_rd_vld;
   logic [AW-1:0] r_rd_idx;
   logic          r_rd_last;

   // 2-entry output FIFO.
   logic [DATA_FFT_SIZE-1:0] r_fifo_dat [2];
   logic [AW-1:0]            r_fifo_idx [2];
   logic [1:0]               r_fifo_last;
   logic                     r_fifo_wptr;
   logic                     r_fifo_rptr;
   logic [1:0]               r_fifo_cnt;

   logic          w_wr;
   logic          w_wwrap;
   logic          w_issue;
   logic          w_ilast;
   logic          w_pop;
   logic          w_credit;
   logic [2:0]    w_occ;
   logic [1:0]    w_set_mask;
   logic [1:0]    w_clr_mask;
   logic [1:0]    w_full_nxt;
   logic          w_wb_nxt;
   logic [AW-1:0] w_rd_idx;

   function automatic logic [AW-1:0] f_rev(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
      return r;
   endfunction

   // Handshakes, read credit and the next value of the bank-full flags.
   always_comb begin
      w_wr     = (r_wstate == W_FILL) && in_valid;
      w_wwrap  = w_wr && (r_wcnt == CNT_LAST);
      w_pop    = (r_fifo_cnt != 2'd0) && out_ready;
      // A slot popped this clk is reusable, so the credit counts it back in.
      w_occ    = {1'b0, r_fifo_cnt} + {2'b00, r_rd_vld};
      w_credit = w_occ < (3'd2 + {2'b00, w_pop});
      w_issue  = w_credit && ((r_rstate == R_RUN) || r_full[r_ib]);
      w_ilast  = w_issue && (r_rcnt == CNT_LAST);
      w_rd_idx = BIT_REVERSE ? f_rev(r_rcnt) : r_rcnt;
      w_wb_nxt = ~r_wb;
      w_set_mask = 2'b00;
      w_clr_mask = 2'b00;
      if (w_wwrap) w_set_mask = r_wb ? 2'b10 : 2'b01;
      // The bank is released once its last read has been issued: from then on
      // its samples live in the read pipeline, so the writer may refill it.
      if (w_ilast) w_clr_mask = r_ib ? 2'b10 : 2'b01;
      w_full_nxt = (r_full | w_set_mask) & ~w_clr_mask;
   end

   // Write FSM next state: stall when the bank we are about to fill is still held.
   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_FILL:  if (w_wwrap && w_full_nxt[w_wb_nxt]) w_wstate_nxt = W_STALL;
         W_STALL: if (!r_full[r_wb])                   w_wstate_nxt = W_FILL;
         default: w_wstate_nxt = W_STALL;
      endcase
   end

   // Read FSM next state: run through one frame of issues, then look for the next full bank.
   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_issue && !w_ilast) w_rstate_nxt = R_RUN;
         R_RUN:   if (w_ilast)             w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   // State registers; the writer leaves reset in W_STALL so in_ready rises one clk after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wstate <= W_STALL;
         r_rstate <= R_IDLE;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_rstate <= w_rstate_nxt;
      end
   end

   // Bank flags, bank pointers and the wrap-around frame counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 2'b00;
         r_wb   <= 1'b0;
         r_ib   <= 1'b0;
         r_wcnt <= '0;
         r_rcnt <= '0;
      end else begin
         r_full <= w_full_nxt;
         if (w_wr)    r_wcnt <= r_wcnt + 1'b1;
         if (w_wwrap) r_wb   <= ~r_wb;
         if (w_issue) r_rcnt <= r_rcnt + 1'b1;
         if (w_ilast) r_ib   <= ~r_ib;
      end
   end

   // Tag the read in flight with its frame position and last flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_vld  <= 1'b0;
         r_rd_idx  <= '0;
         r_rd_last <= 1'b0;
      end else begin
         r_rd_vld  <= w_issue;
         r_rd_idx  <= w_rd_idx;
         r_rd_last <= w_ilast;
      end
   end

   // Output FIFO: capture returning memory data, release on out_valid & out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fifo_dat[0] <= '0;
         r_fifo_dat[1] <= '0;
         r_fifo_idx[0] <= '0;
         r_fifo_idx[1] <= '0;
         r_fifo_last   <= 2'b00;
         r_fifo_wptr   <= 1'b0;
         r_fifo_rptr   <= 1'b0;
         r_fifo_cnt    <= 2'd0;
      end else begin
         if (r_rd_vld) begin
            r_fifo_dat[r_fifo_wptr]  <= mem_outData;
            r_fifo_idx[r_fifo_wptr]  <= r_rd_idx;
            r_fifo_last[r_fifo_wptr] <= r_rd_last;
            r_fifo_wptr              <= ~r_fifo_wptr;
         end
         if (w_pop) r_fifo_rptr <= ~r_fifo_rptr;
         r_fifo_cnt <= r_fifo_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
      end
   end

   // Port drive.
   always_comb begin
      in_ready    = (r_wstate == W_FILL);
      mem_writeEn = w_wr;
      mem_addr    = {r_wb, r_wcnt};
      mem_inData  = w_wr ? in_data : '0;
      mem_addr_r  = {r_ib, w_rd_idx};
      out_valid   = (r_fifo_cnt != 2'd0);
      out_data    = r_fifo_dat[r_fifo_rptr];
      out_index   = r_fifo_idx[r_fifo_rptr];
      out_last    = r_fifo_last[r_fifo_rptr];
      frame_done  = w_pop && r_fifo_last[r_fifo_rptr];
   end

   // A bank is only filled while empty and only released while full, so one clk never sets and clears the same bank.
   a_no_set_clr_same: assert property (@(posedge clk) disable iff (!rst_n) (w_set_mask & w_clr_mask) == 2'b00);
   a_no_wr_full:      assert property (@(posedge clk) disable iff (!rst_n) !(w_wr && r_full[r_wb]));
   a_bank_differ:     assert property (@(posedge clk) disable iff (!rst_n) !(w_wr && w_issue && (r_wb == r_ib)));
   a_fifo_no_ovf:     assert property (@(posedge clk) disable iff (!rst_n) !((r_fifo_cnt == 2'd2) && r_rd_vld && !w_pop));

endmodule

// File: tb/tb_fft_pingpong_ctrl.sv
// Directed bench for fft_pingpong_ctrl: one bit-reversed and one natural-order instance on shared stimulus.
// Latency: each scenario runs bounded cycle loops; outputs sampled on the falling edge.
// Backpressure: out_ready is driven per scenario (held, withheld, or random).
module tb_fft_pingpong_ctrl;
   localparam int DW = 16;
   localparam int AB = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          out_ready;

   logic          in_ready_b, out_valid_b, out_last_b, mem_we_b, frame_done_b;
   logic [DW-1:0] out_data_b, mem_wd_b, mem_rd_b;
   logic [AB-1:0] out_index_b;
   logic [AB:0]   mem_addr_b, mem_addr_r_b;

   logic          in_ready_n, out_valid_n, out_last_n, mem_we_n, frame_done_n;
   logic [DW-1:0] out_data_n, mem_wd_n, mem_rd_n;
   logic [AB-1:0] out_index_n;
   logic [AB:0]   mem_addr_n, mem_addr_r_n;

   logic [DW-1:0] mem_b [16];
   logic [DW-1:0] mem_n [16];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   fft_pingpong_ctrl #(.DATA_FFT_SIZE(DW), .SIZE_BITS_ADDRES(AB), .BIT_REVERSE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
      .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready), .out_last(out_last_b),
      .out_index(out_index_b), .mem_writeEn(mem_we_b), .mem_addr(mem_addr_b), .mem_addr_r(mem_addr_r_b),
      .mem_inData(mem_wd_b), .mem_outData(mem_rd_b), .frame_done(frame_done_b));

   fft_pingpong_ctrl #(.DATA_FFT_SIZE(DW), .SIZE_BITS_ADDRES(AB), .BIT_REVERSE(1'b0)) dut_nat (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_n),
      .out_data(out_data_n), .out_valid(out_valid_n), .out_ready(out_ready), .out_last(out_last_n),
      .out_index(out_index_n), .mem_writeEn(mem_we_n), .mem_addr(mem_addr_n), .mem_addr_r(mem_addr_r_n),
      .mem_inData(mem_wd_n), .mem_outData(mem_rd_n), .frame_done(frame_done_n));

   // memForFFT port 1 models: registered read, write on writeEn.
   always @(posedge clk) begin
      if (mem_we_b) mem_b[mem_addr_b] <= mem_wd_b;
      mem_rd_b <= mem_b[mem_addr_r_b];
      if (mem_we_n) mem_n[mem_addr_n] <= mem_wd_n;
      mem_rd_n <= mem_n[mem_addr_r_n];
   end

   function automatic logic [2:0] brev(input logic [2:0] a);
      return {a[0], a[1], a[2]};
   endfunction

   task automatic test_reset();
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++; if (in_ready_b !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready_b); else n_pass++;
      n_chk++; if (out_valid_b !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid_b); else n_pass++;
      n_chk++; if (out_last_b !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last_b); else n_pass++;
      n_chk++; if (mem_we_b !== 1'b0) $display("FAIL reset_mem_writeEn got %b want 0", mem_we_b); else n_pass++;
      n_chk++; if (frame_done_b !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done_b); else n_pass++;
      n_chk++; if (mem_addr_b !== 4'd0) $display("FAIL reset_mem_addr got %h want 0", mem_addr_b); else n_pass++;
      n_chk++; if (mem_addr_r_b !== 4'd0) $display("FAIL reset_mem_addr_r got %h want 0", mem_addr_r_b); else n_pass++;
      n_chk++; if (out_data_b !== 16'd0) $display("FAIL reset_out_data got %h want 0", out_data_b); else n_pass++;
      n_chk++; if (out_index_b !== 3'd0) $display("FAIL reset_out_index got %h want 0", out_index_b); else n_pass++;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      n_chk++; if (in_ready_b !== 1'b0) $display("FAIL release_in_ready_early got %b want 0", in_ready_b); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (in_ready_b !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready_b); else n_pass++;
      n_chk++; if (in_ready_n !== 1'b1) $display("FAIL release_in_ready_nat got %b want 1", in_ready_n); else n_pass++;
   endtask

   task automatic test_frame_order();
      int nout = 0, ndone = 0, first_cyc = -1, nacc = 0;
      for (int cyc = 0; cyc < 40 && nout < 8; cyc++) begin
         in_valid = (cyc < 8); in_data = 16'(cyc); out_ready = 1'b1;
         @(negedge clk);
         if (in_valid && in_ready_b) nacc++;
         if (frame_done_b) ndone++;
         if (out_valid_b && out_ready) begin
            if (first_cyc < 0) first_cyc = cyc;
            n_chk++; if (out_data_b !== 16'(brev(3'(nout)))) $display("FAIL order_data[%0d] got %h want %h", nout, out_data_b, brev(3'(nout))); else n_pass++;
            n_chk++; if (out_index_b !== brev(3'(nout))) $display("FAIL order_index[%0d] got %0d want %0d", nout, out_index_b, brev(3'(nout))); else n_pass++;
            n_chk++; if (out_last_b !== (nout == 7)) $display("FAIL order_last[%0d] got %b want %b", nout, out_last_b, nout == 7); else n_pass++;
            n_chk++; if (frame_done_b !== (nout == 7)) $display("FAIL order_done[%0d] got %b want %b", nout, frame_done_b, nout == 7); else n_pass++;
            nout++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_chk++; if (nacc != 8) $display("FAIL order_accepted got %0d want 8", nacc); else n_pass++;
      n_chk++; if (nout != 8) $display("FAIL order_count got %0d want 8", nout); else n_pass++;
      n_chk++; if (first_cyc != 10) $display("FAIL order_latency got %0d want 10", first_cyc); else n_pass++;
      n_chk++; if (ndone != 1) $display("FAIL order_frame_done_pulses got %0d want 1", ndone); else n_pass++;
   endtask

   task automatic test_natural_order();
      int nout = 0, ndone = 0;
      for (int cyc = 0; cyc < 40 && nout < 8; cyc++) begin
         in_valid = (cyc < 8); in_data = 16'(cyc); out_ready = 1'b1;
         @(negedge clk);
         if (frame_done_n) ndone++;
         if (out_valid_n && out_ready) begin
            n_chk++; if (out_data_n !== 16'(nout)) $display("FAIL natural_data[%0d] got %h want %h", nout, out_data_n, nout); else n_pass++;
            n_chk++; if (out_index_n !== 3'(nout)) $display("FAIL natural_index[%0d] got %0d want %0d", nout, out_index_n, nout); else n_pass++;
            n_chk++; if (out_last_n !== (nout == 7)) $display("FAIL natural_last[%0d] got %b want %b", nout, out_last_n, nout == 7); else n_pass++;
            nout++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_chk++; if (nout != 8) $display("FAIL natural_count got %0d want 8", nout); else n_pass++;
      n_chk++; if (ndone != 1) $display("FAIL natural_frame_done_pulses got %0d want 1", ndone); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int nsent = 0, nout = 0, nstall = 0, ngap = 0, e;
      for (int cyc = 0; cyc < 120 && nout < 32; cyc++) begin
         in_valid = (nsent < 32); in_data = 16'h0020 + 16'(nsent); out_ready = 1'b1;
         @(negedge clk);
         if (in_valid && !in_ready_b) nstall++;
         if (nout > 0 && !out_valid_b) ngap++;
         if (out_valid_b && out_ready) begin
            e = 32 + (nout / 8) * 8 + int'(brev(3'(nout % 8)));
            n_chk++; if (out_data_b !== 16'(e)) $display("FAIL stream_data[%0d] got %h want %h", nout, out_data_b, e); else n_pass++;
            nout++;
         end
         if (in_valid && in_ready_b) nsent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_chk++; if (nout != 32) $display("FAIL stream_count got %0d want 32", nout); else n_pass++;
      n_chk++; if (nstall != 0) $display("FAIL stream_in_ready_drops got %0d want 0", nstall); else n_pass++;
      n_chk++; if (ngap != 0) $display("FAIL stream_output_gaps got %0d want 0", ngap); else n_pass++;
   endtask

   task automatic test_backpressure();
      int nsent = 0, nout = 0, nbad = 0, nextra = 0, e;
      for (int cyc = 0; cyc < 200 && nout < 24; cyc++) begin
         out_ready = (cyc >= 30); in_valid = (nsent < 24); in_data = 16'(nsent);
         @(negedge clk);
         if (cyc == 29) begin
            n_chk++; if (nsent != 16) $display("FAIL bp_accepted got %0d want 16", nsent); else n_pass++;
            n_chk++; if (in_ready_b !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready_b); else n_pass++;
         end
         if (cyc >= 10 && cyc < 30 && (out_valid_b !== 1'b1 || out_data_b !== 16'h0000 || out_index_b !== 3'd0 || out_last_b !== 1'b0)) nbad++;
         if (out_valid_b && out_ready) begin
            e = (nout / 8) * 8 + int'(brev(3'(nout % 8)));
            n_chk++; if (out_data_b !== 16'(e)) $display("FAIL bp_data[%0d] got %h want %h", nout, out_data_b, e); else n_pass++;
            nout++;
         end
         if (in_valid && in_ready_b) nsent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (out_valid_b) nextra++;
         @(posedge clk); #1;
      end
      n_chk++; if (nbad != 0) $display("FAIL bp_hold_unstable_cycles got %0d want 0", nbad); else n_pass++;
      n_chk++; if (nout != 24) $display("FAIL bp_count got %0d want 24", nout); else n_pass++;
      n_chk++; if (nextra != 0) $display("FAIL bp_extra_outputs got %0d want 0", nextra); else n_pass++;
   endtask

   task automatic test_random();
      logic [DW-1:0] fbuf [8];
      logic [DW-1:0] expb [$];
      logic [DW-1:0] expn [$];
      logic [DW-1:0] eb, en, pd;
      logic [AB-1:0] pi;
      logic          pl;
      logic          hold = 1'b0;
      int nsent = 0, nout = 0;
      for (int cyc = 0; cyc < 4000 && nout < 160; cyc++) begin
         in_valid  = (nsent < 160) && ($urandom_range(0, 1) == 1);
         in_data   = 16'($urandom);
         out_ready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         if (hold) begin
            n_chk++;
            if (out_valid_b !== 1'b1 || out_data_b !== pd || out_index_b !== pi || out_last_b !== pl)
               $display("FAIL rand_hold got v=%b d=%h i=%0d l=%b want v=1 d=%h i=%0d l=%b", out_valid_b, out_data_b, out_index_b, out_last_b, pd, pi, pl);
            else n_pass++;
         end
         hold = out_valid_b && !out_ready;
         pd = out_data_b; pi = out_index_b; pl = out_last_b;
         if (out_valid_b && out_ready) begin
            n_chk++;
            if (expb.size() == 0) $display("FAIL rand_unexpected_output got %h want none", out_data_b);
            else begin
               eb = expb.pop_front(); en = expn.pop_front();
               if (out_data_b !== eb || out_data_n !== en || out_last_b !== (nout % 8 == 7))
                  $display("FAIL rand_data[%0d] got %h/%h last=%b want %h/%h last=%b", nout, out_data_b, out_data_n, out_last_b, eb, en, nout % 8 == 7);
               else n_pass++;
            end
            nout++;
         end
         if (in_valid && in_ready_b) begin
            fbuf[nsent % 8] = in_data;
            nsent++;
            if (nsent % 8 == 0) begin
               for (int p = 0; p < 8; p++) begin
                  expb.push_back(fbuf[brev(3'(p))]);
                  expn.push_back(fbuf[p]);
               end
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_chk++; if (nout != 160) $display("FAIL rand_count got %0d want 160", nout); else n_pass++;
   endtask

   task automatic test_reset_midframe();
      int nsent = 0, nout = 0, nearly = 0, e;
      for (int cyc = 0; cyc < 40 && nsent < 13; cyc++) begin
         out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0300 + 16'(nsent);
         @(negedge clk);
         if (in_valid && in_ready_b) nsent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_chk++; if (out_valid_b !== 1'b1) $display("FAIL midrst_pending_valid got %b want 1", out_valid_b); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_chk++; if (out_valid_b !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid_b); else n_pass++;
      n_chk++; if (out_data_b !== 16'd0) $display("FAIL midrst_out_data got %h want 0", out_data_b); else n_pass++;
      n_chk++; if (in_ready_b !== 1'b0) $display("FAIL midrst_in_ready got %b want 0", in_ready_b); else n_pass++;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      nsent = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         out_ready = 1'b1; in_valid = (nsent < 8); in_data = 16'h0100 + 16'(nsent);
         @(negedge clk);
         if (out_valid_b && nsent < 8) nearly++;
         if (out_valid_b && out_ready) begin
            e = 16'h0100 + int'(brev(3'(nout % 8)));
            n_chk++;
            if (nout >= 8) $display("FAIL midrst_extra_output got %h want none", out_data_b);
            else if (out_data_b !== 16'(e)) $display("FAIL midrst_data[%0d] got %h want %h", nout, out_data_b, e);
            else n_pass++;
            nout++;
         end
         if (in_valid && in_ready_b) nsent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_chk++; if (nearly != 0) $display("FAIL midrst_early_valid got %0d want 0", nearly); else n_pass++;
      n_chk++; if (nout != 8) $display("FAIL midrst_count got %0d want 8", nout); else n_pass++;
   endtask

   initial begin
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      test_reset();
      test_frame_order();
      test_natural_order();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
